// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage ARM64 pipeline: per-stage register
// enables, bubble/flush controls, data-memory wait watchdog and stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter bit          DELAY_SLOT  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_flag_use,
  input  logic             br_taken,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_flag_set,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       wait_cnt_r;
  logic [7:0]       wait_cnt_next_s;
  logic             mem_error_r;
  logic             mem_error_next_s;
  logic [CNT_W-1:0] stall_cycles_r;
  logic             lu_s;
  logic             fh_s;
  logic             eval_hz_s;
  logic             timeout_s;
  logic [8:0]       wait_sum_s;

  // Hazard detection: X31 reads as XZR, so it never creates a load-use dependency.
  always_comb begin
    lu_s = ex_mem_read && (ex_rd != 5'd31) &&
           ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
    fh_s = id_flag_use && ex_flag_set;
    // The request cycle in RUN is the first frozen cycle, so the whole access
    // (frozen cycles plus the forced release) spans MEM_TIMEOUT cycles.
    wait_sum_s = {1'b0, wait_cnt_r} + 9'd2;
    timeout_s  = (wait_sum_s >= 9'(MEM_TIMEOUT));
  end

  // Stall/flush decode and next-state logic.
  always_comb begin
    pc_en            = 1'b1;
    ifid_en          = 1'b1;
    idex_en          = 1'b1;
    exmem_en         = 1'b1;
    memwb_en         = 1'b1;
    ifid_flush       = 1'b0;
    idex_bubble      = 1'b0;
    memwb_bubble     = 1'b0;
    eval_hz_s        = 1'b0;
    state_next_s     = state_r;
    wait_cnt_next_s  = wait_cnt_r;
    mem_error_next_s = mem_error_r;
    if (!reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            pc_en           = 1'b0;
            ifid_en         = 1'b0;
            idex_en         = 1'b0;
            exmem_en        = 1'b0;
            memwb_bubble    = 1'b1;
            state_next_s    = ST_MEM_WAIT;
            wait_cnt_next_s = 8'd0;
          end else begin
            eval_hz_s = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            eval_hz_s       = 1'b1;
            state_next_s    = ST_RUN;
            wait_cnt_next_s = 8'd0;
          end else if (timeout_s) begin
            eval_hz_s        = 1'b1;
            memwb_bubble     = 1'b1;
            mem_error_next_s = 1'b1;
            state_next_s     = ST_RUN;
            wait_cnt_next_s  = 8'd0;
          end else begin
            pc_en           = 1'b0;
            ifid_en         = 1'b0;
            idex_en         = 1'b0;
            exmem_en        = 1'b0;
            memwb_bubble    = 1'b1;
            wait_cnt_next_s = wait_cnt_r + 8'd1;
          end
        end
        default: begin
          state_next_s    = ST_RUN;
          wait_cnt_next_s = 8'd0;
        end
      endcase
      if (eval_hz_s) begin
        if (lu_s || fh_s) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end else if (br_taken && !DELAY_SLOT) begin
          ifid_flush = 1'b1;
        end else begin
          ifid_flush = 1'b0;
        end
      end else begin
        eval_hz_s = 1'b0;
      end
    end
  end

  // State, watchdog and saturating stall counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_RUN;
      wait_cnt_r     <= 8'd0;
      mem_error_r    <= 1'b0;
      stall_cycles_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      wait_cnt_r  <= wait_cnt_next_s;
      mem_error_r <= mem_error_next_s;
      if (!pc_en && (stall_cycles_r != {CNT_W{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  assign mem_error    = mem_error_r;
  assign stall_cycles = stall_cycles_r;

endmodule
